debug_responder: RTL and testbench
==================================

DEBUG_RESPONDER -- requirements
Module: debug_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 6: instruction-memory word address width.
REQ-002 Parameter MAX_INSTRUCTION, default 64: maximum number of words per program load.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000: load inactivity limit, used only when DEBUG_RESP_TIMEOUT_EN is defined.
REQ-004 Ports shall be:
- i_clk  in  1  single clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle pulse qualifying i_rx_data.
- o_tx_data  out  8  byte to transmit.
- o_tx_start  out  1  one-cycle transmit request.
- i_tx_done  in  1  one-cycle pulse when the byte has been sent.
- o_imem_we  out  1  instruction-memory write strobe.
- o_imem_addr  out  ADDR_WIDTH  write word address.
- o_imem_wdata  out  32  write word.
- o_reg_addr  out  5  register-file read address.
- i_reg_data  in  32  combinational register-file read data.
- i_pc  in  32  current PC.
- i_if_id  in  64  IF/ID latch.
- i_id_ex  in  129  ID/EX latch.
- i_ex_mem  in  78  EX/MEM latch.
- i_mem_wb  in  72  MEM/WB latch.
- o_cpu_en  out  1  CPU clock enable.
- o_step_mode  out  1  1 = step mode, 0 = continuous mode.
- o_cpu_rst  out  1  one-cycle CPU/PC reset pulse.

Function
REQ-005 The FSM shall have states IDLE, LOAD_CNT, LOAD_DATA, TX_BYTE, TX_WAIT and TX_READY.
REQ-006 In IDLE, an i_rx_valid byte shall be decoded as a command:
- 0x01: send registers.
- 0x02/0x03/0x04/0x05: send the IF/ID, ID/EX, EX/MEM or MEM/WB latch.
- 0x07: go to LOAD_CNT.
- 0x08: clear o_step_mode.
- 0x09: set o_step_mode.
- 0x0A: step.
- 0x0B: send PC.
- 0x0D: start.
- Any other byte: ignored, no reply.
REQ-007 Send commands shall snapshot the selected latch or i_pc zero-extended to whole bytes in the decode cycle, giving 8/17/10/9/4 bytes for 0x02/0x03/0x04/0x05/0x0B.
REQ-008 Command 0x01 shall send 128 bytes: registers 0..31 in order, 4 bytes each; i_reg_data shall be sampled with o_reg_addr=k when the first byte of register k is loaded.
REQ-009 All multi-byte fields shall be sent LSB first.
REQ-010 In TX_BYTE, o_tx_start shall pulse for one cycle; o_tx_data shall be held stable until i_tx_done.
REQ-011 The next byte's o_tx_start shall occur exactly 1 cycle after i_tx_done.
REQ-012 After the last data byte, TX_READY shall transmit 0x52 ('R') and then return to IDLE.
REQ-013 i_rx_valid bytes arriving outside IDLE, LOAD_CNT and LOAD_DATA shall be dropped.
REQ-014 LOAD_CNT: the next byte N shall be handled as follows:
- N=0: send 'R'.
- N>MAX_INSTRUCTION: send 0x45 ('E').
- 1..MAX_INSTRUCTION: clear o_cpu_en, then go to LOAD_DATA with word address 0.
REQ-015 LOAD_DATA: bytes shall be assembled LSB first; the cycle after the 4th byte, o_imem_we shall pulse one cycle with the word and current address, and the address shall then increment.
REQ-016 After word N-1 is written, the block shall send 'R'.
REQ-017 Command 0x0D shall pulse o_cpu_rst for one cycle, set o_cpu_en if o_step_mode=0, and send 'R'.
REQ-018 Command 0x0A with o_step_mode=1 shall pulse o_cpu_en for exactly one cycle, with no reply; with o_step_mode=0 it shall be ignored.
REQ-019 Command 0x08 shall set o_cpu_en after a prior 0x0D; commands 0x08/0x09 shall send no reply.
REQ-020 Command 0x09 shall clear o_cpu_en on the next cycle.
REQ-021 o_tx_start and o_imem_we shall never be asserted in the same cycle.

Reset
REQ-022 On i_rst the FSM shall go to IDLE, the byte/word counters shall clear, and the following outputs shall be 0: o_tx_start, o_tx_data, o_imem_we, o_imem_addr, o_imem_wdata, o_reg_addr, o_cpu_en, o_cpu_rst.
REQ-023 On i_rst, o_step_mode shall reset to 0.
REQ-024 A reset mid-transfer shall abort the transfer with no further output bytes.

Configuration
REQ-025 With DEBUG_RESP_TIMEOUT_EN defined, if TIMEOUT_CYCLES cycles elapse with no i_rx_valid in LOAD_CNT/LOAD_DATA, the block shall abort and send 'E'; words already written shall remain written.
REQ-026 Without DEBUG_RESP_TIMEOUT_EN, LOAD_CNT/LOAD_DATA shall wait indefinitely and no timeout counter shall exist.

Verification
REQ-027 Load: 0x07, 0x02, then bytes 03 00 01 3C 01 00 02 3C -> writes addr0=0x3C010003 and addr1=0x3C020001, then 'R'.
REQ-028 Latch dump: i_if_id=0x0123456789ABCDEF, then 0x02 -> EF CD AB 89 67 45 23 01 'R'; 0x03 -> 17 bytes with byte 16 = i_id_ex[128].
REQ-029 Registers: reg k=k*0x01010101, then 0x01 -> 128 bytes, bytes 4..7 = 01 01 01 01, then 'R'.
REQ-030 Step: 0x09, 0x0D, 0x0A, 0x0A -> 'R' once; exactly two single-cycle o_cpu_en pulses.
REQ-031 Error/timeout: 0x07, 0x41 -> 'E'; with the macro defined, 0x07, 0x02 then silence -> 'E' after TIMEOUT_CYCLES.
REQ-032 Reset: assert i_rst during byte 50 of a 0x01 dump -> no further o_tx_start; IDLE and outputs zero.

Source files
------------

// File: rtl/debug_responder.sv
// debug_responder: byte-oriented debug monitor for a pipelined CPU.
// Commands arrive one byte at a time. The block answers with register, latch
// or PC dumps, loads programs into instruction memory and controls the CPU
// clock enable, run/step mode and reset.
//
// Optional feature: define DEBUG_RESP_TIMEOUT_EN to abort a stalled program
// load after TIMEOUT_CYCLES quiet cycles and reply 'E'.
//
// Handshakes:
//   rx: i_rx_valid is a one-cycle pulse with no backpressure. A byte is
//       consumed only in IDLE, LOAD_CNT or LOAD_DATA; in any other state it
//       is dropped.
//   tx: o_tx_start is a one-cycle request. o_tx_data is stable from that cycle
//       until i_tx_done. The next request comes exactly one cycle after
//       i_tx_done.
//
// Ports:
//   i_clk, i_rst                    clock, async active-high reset
//   i_rx_data/i_rx_valid            received command/data byte
//   o_tx_data/o_tx_start/i_tx_done  transmit byte interface
//   o_imem_we/addr/wdata            instruction-memory write port
//   o_reg_addr/i_reg_data           register-file read port (comb read)
//   i_pc, i_if_id .. i_mem_wb       CPU state to dump
//   o_cpu_en/o_step_mode/o_cpu_rst  CPU run control
module debug_responder #(
  parameter int ADDR_WIDTH      = 6,
  parameter int MAX_INSTRUCTION = 64,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [31:0]           o_imem_wdata,
  output logic [4:0]            o_reg_addr,
  input  logic [31:0]           i_reg_data,
  input  logic [31:0]           i_pc,
  input  logic [63:0]           i_if_id,
  input  logic [128:0]          i_id_ex,
  input  logic [77:0]           i_ex_mem,
  input  logic [71:0]           i_mem_wb,
  output logic                  o_cpu_en,
  output logic                  o_step_mode,
  output logic                  o_cpu_rst
);

  typedef enum logic [2:0] {
    IDLE, LOAD_CNT, LOAD_DATA, TX_BYTE, TX_WAIT, TX_READY
  } state_t;

  state_t       state, state_next;
  logic [135:0] shreg;        // remaining bytes of the snapshot, LSB first
  logic [135:0] snap;
  logic [7:0]   snap_len, tx_len, byte_idx;
  logic         is_send_cmd, tx_regs, last_q, started;
  logic [7:0]   load_n, words_done;
  logic [1:0]   byte_cnt;
  logic         n_too_big, load_done, reply_err, timeout_hit;

  // Start pulses come straight from the state so they are single-cycle and
  // can never coincide with o_imem_we (only asserted in LOAD_DATA).
  assign o_tx_start = (state == TX_BYTE) || (state == TX_READY);
  // byte_idx is 0 in IDLE, so register 0 is presented when 0x01 is decoded.
  assign o_reg_addr = byte_idx[6:2];

  assign n_too_big = 32'(i_rx_data) > 32'(MAX_INSTRUCTION);
  assign load_done = (state == LOAD_DATA) && o_imem_we && (words_done + 8'd1 == load_n);
  assign reply_err = ((state == LOAD_CNT) && i_rx_valid && (i_rx_data != 8'h00)) ||
                     (timeout_hit && !load_done);

  // Snapshot source and length for the send commands, zero-extended to bytes.
  always_comb begin
    snap        = '0;
    snap_len    = 8'd0;
    is_send_cmd = 1'b0;
    case (i_rx_data)
      8'h01: begin snap_len = 8'd128; is_send_cmd = 1'b1; end
      8'h02: begin snap = {72'd0, i_if_id};   snap_len = 8'd8;  is_send_cmd = 1'b1; end
      8'h03: begin snap = {7'd0, i_id_ex};    snap_len = 8'd17; is_send_cmd = 1'b1; end
      8'h04: begin snap = {58'd0, i_ex_mem};  snap_len = 8'd10; is_send_cmd = 1'b1; end
      8'h05: begin snap = {64'd0, i_mem_wb};  snap_len = 8'd9;  is_send_cmd = 1'b1; end
      8'h0B: begin snap = {104'd0, i_pc};     snap_len = 8'd4;  is_send_cmd = 1'b1; end
      default: ;
    endcase
  end

`ifdef DEBUG_RESP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] quiet_cnt;
  logic            in_load;

  assign in_load     = (state == LOAD_CNT) || (state == LOAD_DATA);
  assign timeout_hit = in_load && !i_rx_valid && (quiet_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                      quiet_cnt <= '0;
    else if (!in_load || i_rx_valid) quiet_cnt <= '0;
    else                            quiet_cnt <= quiet_cnt + TO_W'(1);
  end
`else
  logic timeout_cfg_unused;
  assign timeout_hit        = 1'b0;
  assign timeout_cfg_unused = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_rx_valid) begin
          if (is_send_cmd)              state_next = TX_BYTE;
          else if (i_rx_data == 8'h07)  state_next = LOAD_CNT;
          else if (i_rx_data == 8'h0D)  state_next = TX_READY;
        end
      end
      LOAD_CNT: begin
        if (timeout_hit)
          state_next = TX_READY;
        else if (i_rx_valid)
          state_next = ((i_rx_data == 8'h00) || n_too_big) ? TX_READY : LOAD_DATA;
      end
      LOAD_DATA: if (load_done || timeout_hit) state_next = TX_READY;
      TX_BYTE:   state_next = TX_WAIT;
      TX_WAIT: begin
        if (i_tx_done) begin
          if (last_q)                  state_next = IDLE;
          else if (byte_idx == tx_len) state_next = TX_READY;
          else                         state_next = TX_BYTE;
        end
      end
      TX_READY:  state_next = TX_WAIT;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_tx_data    <= 8'd0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= 32'd0;
      o_cpu_en     <= 1'b0;
      o_step_mode  <= 1'b0;
      o_cpu_rst    <= 1'b0;
      shreg        <= '0;
      tx_len       <= 8'd0;
      byte_idx     <= 8'd0;
      tx_regs      <= 1'b0;
      last_q       <= 1'b0;
      started      <= 1'b0;
      load_n       <= 8'd0;
      words_done   <= 8'd0;
      byte_cnt     <= 2'd0;
    end else begin
      o_cpu_rst <= 1'b0;
      o_imem_we <= 1'b0;
      // In step mode the enable is only ever a one-cycle pulse.
      if (o_step_mode && o_cpu_en) o_cpu_en <= 1'b0;
      if (o_imem_we) begin
        o_imem_addr <= o_imem_addr + ADDR_WIDTH'(1);
        words_done  <= words_done + 8'd1;
      end

      case (state)
        IDLE: begin
          if (i_rx_valid) begin
            if (is_send_cmd) begin
              tx_len   <= snap_len;
              tx_regs  <= (i_rx_data == 8'h01);
              byte_idx <= 8'd1;
              if (i_rx_data == 8'h01) begin
                o_tx_data <= i_reg_data[7:0];
                shreg     <= {112'd0, i_reg_data[31:8]};
              end else begin
                o_tx_data <= snap[7:0];
                shreg     <= {8'd0, snap[135:8]};
              end
            end
            case (i_rx_data)
              8'h08: begin
                o_step_mode <= 1'b0;
                if (started) o_cpu_en <= 1'b1;
              end
              8'h09: begin
                o_step_mode <= 1'b1;
                o_cpu_en    <= 1'b0;
              end
              8'h0A: if (o_step_mode) o_cpu_en <= 1'b1;
              8'h0D: begin
                o_cpu_rst <= 1'b1;
                started   <= 1'b1;
                o_cpu_en  <= !o_step_mode;
              end
              default: ;
            endcase
          end
        end
        LOAD_CNT: begin
          if (i_rx_valid && (state_next == LOAD_DATA)) begin
            load_n      <= i_rx_data;
            o_cpu_en    <= 1'b0;
            o_imem_addr <= '0;
            words_done  <= 8'd0;
            byte_cnt    <= 2'd0;
          end
        end
        LOAD_DATA: begin
          if (i_rx_valid) begin
            o_imem_wdata <= {i_rx_data, o_imem_wdata[31:8]};
            byte_cnt     <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) o_imem_we <= 1'b1;
          end
        end
        TX_WAIT: begin
          if (i_tx_done) begin
            if (last_q) begin
              last_q   <= 1'b0;
              byte_idx <= 8'd0;
              tx_regs  <= 1'b0;
            end else if (byte_idx != tx_len) begin
              byte_idx <= byte_idx + 8'd1;
              // First byte of each register: fresh read with o_reg_addr = k.
              if (tx_regs && (byte_idx[1:0] == 2'd0)) begin
                o_tx_data <= i_reg_data[7:0];
                shreg     <= {112'd0, i_reg_data[31:8]};
              end else begin
                o_tx_data <= shreg[7:0];
                shreg     <= {8'd0, shreg[135:8]};
              end
            end
          end
        end
        default: ;
      endcase

      // Every reply ends with a single status byte sent from TX_READY.
      if ((state_next == TX_READY) && (state != TX_READY)) begin
        last_q    <= 1'b1;
        o_tx_data <= reply_err ? 8'h45 : 8'h52;
      end
    end
  end

endmodule

// File: tb/tb_debug_responder.sv
module tb_debug_responder;
  localparam int AW = 6;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [7:0]    i_rx_data;
  logic          i_rx_valid;
  logic [7:0]    o_tx_data;
  logic          o_tx_start;
  logic          i_tx_done;
  logic          o_imem_we;
  logic [AW-1:0] o_imem_addr;
  logic [31:0]   o_imem_wdata;
  logic [4:0]    o_reg_addr;
  logic [31:0]   i_reg_data;
  logic [31:0]   i_pc;
  logic [63:0]   i_if_id;
  logic [128:0]  i_id_ex;
  logic [77:0]   i_ex_mem;
  logic [71:0]   i_mem_wb;
  logic          o_cpu_en;
  logic          o_step_mode;
  logic          o_cpu_rst;

  debug_responder #(.ADDR_WIDTH(AW), .MAX_INSTRUCTION(64), .TIMEOUT_CYCLES(1000000)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
    .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data),
    .i_pc(i_pc), .i_if_id(i_if_id), .i_id_ex(i_id_ex), .i_ex_mem(i_ex_mem), .i_mem_wb(i_mem_wb),
    .o_cpu_en(o_cpu_en), .o_step_mode(o_step_mode), .o_cpu_rst(o_cpu_rst)
  );

  // Clock / reset
  always #5 i_clk = ~i_clk;

  // Register file model: register k holds k*0x01010101.
  assign i_reg_data = {4{3'b000, o_reg_addr}};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_done_cyc = -10;
  int gap1_cnt = 0, hold_err = 0, start_err = 0, overlap_cnt = 0;
  int en_high = 0, en_rise = 0, rst_high = 0;
  int rd_ptr = 0;
  bit in_rst_test = 1'b0;
  logic en_prev = 1'b0;

  logic [7:0]    cap_q[$];
  logic [7:0]    exp_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  // Observers on the falling edge.
  always @(negedge i_clk) begin
    if (o_imem_we) begin
      wr_addr_q.push_back(o_imem_addr);
      wr_data_q.push_back(o_imem_wdata);
    end
    if (o_imem_we && o_tx_start) overlap_cnt++;
    if (o_cpu_en) en_high++;
    if (o_cpu_en && !en_prev) en_rise++;
    en_prev = o_cpu_en;
    if (o_cpu_rst) rst_high++;
  end

  // UART transmitter model: 3 busy cycles, then a one-cycle i_tx_done.
  initial begin : tx_model
    logic [7:0] hold;
    i_tx_done = 1'b0;
    forever begin
      @(negedge i_clk);
      i_tx_done = 1'b0;
      if (o_tx_start) begin
        if (cyc - last_done_cyc == 1) gap1_cnt++;
        cap_q.push_back(o_tx_data);
        hold = o_tx_data;
        repeat (3) begin
          @(negedge i_clk);
          if (!in_rst_test) begin
            if (o_tx_data !== hold) hold_err++;
            if (o_tx_start) start_err++;
          end
        end
        i_tx_done = 1'b1;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
    repeat (2) @(negedge i_clk);
  endtask

  // Scoreboard: compare captured tx bytes against exp_q, then confirm silence.
  task automatic check_tx(input string tag);
    int n;
    int t;
    logic [7:0] e;
    logic [7:0] g;
    n = exp_q.size();
    t = 0;
    while ((cap_q.size() < rd_ptr + n) && (t < 5000)) begin
      @(negedge i_clk);
      t++;
    end
    check({tag, "_arrive"}, 64'(t < 5000), 64'd1);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      g = (rd_ptr < cap_q.size()) ? cap_q[rd_ptr] : 8'hxx;
      check($sformatf("%s_b%0d", tag, i), 64'(g), 64'(e));
      rd_ptr++;
    end
    repeat (30) @(negedge i_clk);
    check({tag, "_extra"}, 64'(cap_q.size()), 64'(rd_ptr));
  endtask

  initial begin : main
    int g0, eh0, er0, rh0, base, t;
    i_rst = 1'b1;
    i_rx_data = 8'h00;
    i_rx_valid = 1'b0;
    i_pc = 32'hDEADBEEF;
    i_if_id = 64'h0123456789ABCDEF;
    i_id_ex = {1'b1, 64'hFEDCBA9876543210, 64'h0011223344556677};
    i_ex_mem = {14'h2ABC, 64'h1122334455667788};
    i_mem_wb = {8'hA5, 64'h0102030405060708};
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Reset state
    check("rst_tx_start", 64'(o_tx_start), 64'd0);
    check("rst_tx_data", 64'(o_tx_data), 64'd0);
    check("rst_imem_we", 64'(o_imem_we), 64'd0);
    check("rst_imem_addr", 64'(o_imem_addr), 64'd0);
    check("rst_imem_wdata", 64'(o_imem_wdata), 64'd0);
    check("rst_reg_addr", 64'(o_reg_addr), 64'd0);
    check("rst_cpu_en", 64'(o_cpu_en), 64'd0);
    check("rst_step", 64'(o_step_mode), 64'd0);
    check("rst_cpu_rst", 64'(o_cpu_rst), 64'd0);

    // Program load of two words
    send_byte(8'h07); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h01); send_byte(8'h3C);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h02); send_byte(8'h3C);
    exp_q = {8'h52};
    check_tx("load2");
    check("load2_nwr", 64'(wr_addr_q.size()), 64'd2);
    check("load2_a0", 64'(wr_addr_q[0]), 64'd0);
    check("load2_d0", 64'(wr_data_q[0]), 64'h3C010003);
    check("load2_a1", 64'(wr_addr_q[1]), 64'd1);
    check("load2_d1", 64'(wr_data_q[1]), 64'h3C020001);

    // IF/ID dump, all gaps after tx_done exactly one cycle
    g0 = gap1_cnt;
    send_byte(8'h02);
    exp_q = {8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h52};
    check_tx("ifid");
    check("ifid_gap1", 64'(gap1_cnt - g0), 64'd8);

    // ID/EX dump: input changes right after decode must not leak in
    @(negedge i_clk);
    i_rx_data = 8'h03; i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
    i_id_ex = '0;
    exp_q = {8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00,
             8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE, 8'h01, 8'h52};
    check_tx("idex");

    send_byte(8'h04);
    exp_q = {8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'hBC, 8'h2A, 8'h52};
    check_tx("exmem");

    send_byte(8'h05);
    exp_q = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'hA5, 8'h52};
    check_tx("memwb");

    send_byte(8'h0B);
    exp_q = {8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h52};
    check_tx("pc");

    // Register dump: 32 registers x 4 bytes, then 'R'
    g0 = gap1_cnt;
    send_byte(8'h01);
    for (int k = 0; k < 32; k++)
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(k));
    exp_q.push_back(8'h52);
    check_tx("regs");
    check("regs_gap1", 64'(gap1_cnt - g0), 64'd128);

    // Unknown commands, step with step mode off, 0x08 before any start
    eh0 = en_high;
    send_byte(8'h06); send_byte(8'hFF); send_byte(8'h0A); send_byte(8'h08);
    check_tx("ignored");
    check("ignored_en", 64'(en_high - eh0), 64'd0);

    // Load count boundaries
    send_byte(8'h07); send_byte(8'h41);
    exp_q = {8'h45};
    check_tx("cnt65");
    send_byte(8'h07); send_byte(8'h00);
    exp_q = {8'h52};
    check_tx("cnt0");
    check("cnt_nwr", 64'(wr_addr_q.size()), 64'd2);

    // Bytes arriving during a transmission are dropped
    send_byte(8'h0B); send_byte(8'h02);
    exp_q = {8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h52};
    check_tx("drop");

    // Start in continuous mode
    rh0 = rst_high;
    send_byte(8'h0D);
    exp_q = {8'h52};
    check_tx("start");
    check("start_rst_pulse", 64'(rst_high - rh0), 64'd1);
    check("start_cpu_en", 64'(o_cpu_en), 64'd1);

    // Single-word load stops the CPU
    send_byte(8'h07); send_byte(8'h01);
    send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE); send_byte(8'hCA);
    exp_q = {8'h52};
    check_tx("load1");
    check("load1_nwr", 64'(wr_addr_q.size()), 64'd3);
    check("load1_a", 64'(wr_addr_q[2]), 64'd0);
    check("load1_d", 64'(wr_data_q[2]), 64'hCAFEF00D);
    check("load1_cpu_en", 64'(o_cpu_en), 64'd0);

    // Step sequence
    send_byte(8'h09);
    check("step_mode_set", 64'(o_step_mode), 64'd1);
    eh0 = en_high; er0 = en_rise; rh0 = rst_high;
    send_byte(8'h0D);
    exp_q = {8'h52};
    check_tx("step_start");
    check("step_rst_pulse", 64'(rst_high - rh0), 64'd1);
    send_byte(8'h0A); send_byte(8'h0A);
    repeat (10) @(negedge i_clk);
    check("step_en_cycles", 64'(en_high - eh0), 64'd2);
    check("step_en_pulses", 64'(en_rise - er0), 64'd2);
    check("step_no_reply", 64'(cap_q.size()), 64'(rd_ptr));

    // Back to continuous resumes the CPU; step mode stops it again
    send_byte(8'h08);
    check("cont_mode", 64'(o_step_mode), 64'd0);
    check("cont_cpu_en", 64'(o_cpu_en), 64'd1);
    send_byte(8'h09);
    check("stop_cpu_en", 64'(o_cpu_en), 64'd0);

    // Reset during byte 50 of a register dump
    in_rst_test = 1'b1;
    send_byte(8'h01);
    t = 0;
    while ((cap_q.size() < rd_ptr + 50) && (t < 5000)) begin
      @(negedge i_clk);
      t++;
    end
    check("rst_mid_reach", 64'(t < 5000), 64'd1);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    base = cap_q.size();
    repeat (200) @(negedge i_clk);
    check("rst_mid_no_tx", 64'(cap_q.size()), 64'(base));
    check("rst_mid_tx_data", 64'(o_tx_data), 64'd0);
    check("rst_mid_reg_addr", 64'(o_reg_addr), 64'd0);
    check("rst_mid_step", 64'(o_step_mode), 64'd0);
    check("rst_mid_cpu_en", 64'(o_cpu_en), 64'd0);
    check("rst_mid_we", 64'(o_imem_we), 64'd0);

    // Protocol invariants watched throughout the run
    check("tx_data_hold", 64'(hold_err), 64'd0);
    check("tx_start_single", 64'(start_err), 64'd0);
    check("tx_we_overlap", 64'(overlap_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
